// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: synchroniser, debounce, press/release
// pulses and optional per-channel auto-repeat of press pulses while held.
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    input  logic [N_BTN-1:0] i_repeat_en,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic             o_any
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RATE  = 2'd2
    } rpt_state_e;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q,      sync_d;
        logic [DB_W-1:0]        db_cnt_q,    db_cnt_d;
        logic                   level_q,     level_d;
        logic                   press_q,     press_d;
        logic                   release_q,   release_d;
        logic [RPT_W-1:0]       rpt_cnt_q,   rpt_cnt_d;
        rpt_state_e             rpt_state_q, rpt_state_d;
        logic                   btn_s;
        logic                   rise;
        logic                   fall;
        logic                   rpt_pulse;

        always_ff @(posedge clk) begin
            if (!rst) begin
                sync_q      <= '0;
                db_cnt_q    <= '0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                rpt_cnt_q   <= '0;
                rpt_state_q <= RPT_IDLE;
            end else begin
                sync_q      <= sync_d;
                db_cnt_q    <= db_cnt_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                rpt_cnt_q   <= rpt_cnt_d;
                rpt_state_q <= rpt_state_d;
            end
        end

        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], i_btn[g]};
            btn_s  = sync_q[SYNC_STAGES-1];

            // Counter only runs while the synchronised input disagrees with
            // the debounced level; any agreeing sample restarts it.
            level_d  = level_q;
            db_cnt_d = '0;
            if (btn_s != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    level_d = ~level_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            rise = level_d & ~level_q;
            fall = ~level_d & level_q;

            rpt_state_d = rpt_state_q;
            rpt_cnt_d   = rpt_cnt_q;
            rpt_pulse   = 1'b0;
            case (rpt_state_q)
                RPT_IDLE: begin
                    rpt_cnt_d = '0;
                    // Covers both the press edge and re-enable while held.
                    if (level_d && i_repeat_en[g]) begin
                        rpt_state_d = RPT_DELAY;
                    end
                end
                RPT_DELAY: begin
                    if (!level_d || !i_repeat_en[g]) begin
                        rpt_state_d = RPT_IDLE;
                        rpt_cnt_d   = '0;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        rpt_pulse   = 1'b1;
                        rpt_state_d = RPT_RATE;
                        rpt_cnt_d   = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                RPT_RATE: begin
                    if (!level_d || !i_repeat_en[g]) begin
                        rpt_state_d = RPT_IDLE;
                        rpt_cnt_d   = '0;
                    end else if (rpt_cnt_q == RATE_LAST) begin
                        rpt_pulse = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    rpt_state_d = RPT_IDLE;
                    rpt_cnt_d   = '0;
                end
            endcase

            press_d   = rise | rpt_pulse;
            release_d = fall;
        end

        assign o_level[g]   = level_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
    end

    assign o_any = |o_level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected press/release events are
// scheduled by edge number when stimulus is driven and checked every cycle.
module tb_btn_conditioner;

    localparam int N   = 5;
    localparam int LAT = 10;   // drive cycle to o_level edge: 1 + SYNC_STAGES + DEBOUNCE_CYCLES - 1
    localparam int RD  = 64;
    localparam int RR  = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i_btn;
    logic [N-1:0] i_repeat_en;
    logic [N-1:0] o_level;
    logic [N-1:0] o_press;
    logic [N-1:0] o_release;
    logic         o_any;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } ev_t;

    ev_t          sb_q[$];
    int           cyc    = 0;
    int           n_vec  = 0;
    int           n_miss = 0;
    logic [N-1:0] exp_level = '0;
    int           p;

    btn_conditioner #(
        .N_BTN          (N),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn      (i_btn),
        .i_repeat_en(i_repeat_en),
        .o_level    (o_level),
        .o_press    (o_press),
        .o_release  (o_release),
        .o_any      (o_any)
    );

    always #5 clk = ~clk;

    task automatic expect_ev(input int c, input logic [N-1:0] pm, input logic [N-1:0] rm);
        ev_t e;
        int  idx;
        bit  merged;
        e.cyc   = c;
        e.press = pm;
        e.rel   = rm;
        idx     = sb_q.size();
        merged  = 1'b0;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (!merged && idx == sb_q.size()) begin
                if (sb_q[i].cyc == c) begin
                    sb_q[i].press = sb_q[i].press | pm;
                    sb_q[i].rel   = sb_q[i].rel | rm;
                    merged        = 1'b1;
                end else if (sb_q[i].cyc > c) begin
                    idx = i;
                end
            end
        end
        if (!merged) sb_q.insert(idx, e);
    endtask

    task automatic step(input int n);
        logic         rst_s;
        logic [N-1:0] exp_p;
        logic [N-1:0] exp_r;
        for (int s = 0; s < n; s++) begin
            rst_s = rst;
            @(posedge clk);
            cyc++;
            #1;
            exp_p = '0;
            exp_r = '0;
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                n_vec++;
                n_miss++;
                $error("FAIL missed_event cyc=%0d got=none required_at=%0d", cyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                exp_p = sb_q[0].press;
                exp_r = sb_q[0].rel;
                void'(sb_q.pop_front());
            end
            if (!rst_s) exp_level = '0;
            else        exp_level = (exp_level | exp_p) & ~exp_r;

            n_vec++;
            assert (o_press === exp_p) else begin
                n_miss++;
                $error("FAIL press cyc=%0d got=%b exp=%b", cyc, o_press, exp_p);
            end
            n_vec++;
            assert (o_release === exp_r) else begin
                n_miss++;
                $error("FAIL release cyc=%0d got=%b exp=%b", cyc, o_release, exp_r);
            end
            n_vec++;
            assert (o_level === exp_level) else begin
                n_miss++;
                $error("FAIL level cyc=%0d got=%b exp=%b", cyc, o_level, exp_level);
            end
            n_vec++;
            assert (o_any === (|exp_level)) else begin
                n_miss++;
                $error("FAIL any cyc=%0d got=%b exp=%b", cyc, o_any, |exp_level);
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        i_btn       = '0;
        i_repeat_en = '0;
        step(3);
        rst = 1'b1;
        step(5);

        // Clean press and release on ch0
        i_btn[0] = 1'b1;
        expect_ev(cyc + LAT, 5'b00001, 5'b00000);
        step(40);
        i_btn[0] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b00001);
        step(20);

        // Bounce train on ch4: lows of 5 are too short to drop the level
        for (int r = 0; r < 20; r++) begin
            i_btn[4] = 1'b1;
            if (r == 0) expect_ev(cyc + LAT, 5'b10000, 5'b00000);
            step(10);
            i_btn[4] = 1'b0;
            if (r == 19) expect_ev(cyc + LAT, 5'b00000, 5'b10000);
            step(5);
        end
        step(15);

        // Glitch rejection on ch2: 7 cycles rejected, 8 accepted
        i_btn[2] = 1'b1;
        step(7);
        i_btn[2] = 1'b0;
        step(20);
        i_btn[2] = 1'b1;
        expect_ev(cyc + LAT, 5'b00100, 5'b00000);
        step(8);
        i_btn[2] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b00100);
        step(20);

        // Auto-repeat on ch1, held 200 edges after the press edge
        i_repeat_en[1] = 1'b1;
        i_btn[1]       = 1'b1;
        p = cyc + LAT;
        expect_ev(p, 5'b00010, 5'b00000);
        for (int n = 0; n < 9; n++) expect_ev(p + RD + n * RR, 5'b00010, 5'b00000);
        step(p + 190 - cyc);
        i_btn[1] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b00010);
        step(20);

        // Same hold with repeat disabled
        i_repeat_en[1] = 1'b0;
        i_btn[1]       = 1'b1;
        p = cyc + LAT;
        expect_ev(p, 5'b00010, 5'b00000);
        step(p + 190 - cyc);
        i_btn[1] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b00010);
        step(20);

        // Repeat disabled at edge P+70
        i_repeat_en[1] = 1'b1;
        i_btn[1]       = 1'b1;
        p = cyc + LAT;
        expect_ev(p, 5'b00010, 5'b00000);
        expect_ev(p + RD, 5'b00010, 5'b00000);
        step(p + 69 - cyc);
        i_repeat_en[1] = 1'b0;
        step(p + 190 - cyc);
        i_btn[1] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b00010);
        step(20);

        // Repeat enabled at edge P+30 while already held
        i_btn[1] = 1'b1;
        p = cyc + LAT;
        expect_ev(p, 5'b00010, 5'b00000);
        step(p + 29 - cyc);
        i_repeat_en[1] = 1'b1;
        expect_ev(p + 30 + RD,          5'b00010, 5'b00000);
        expect_ev(p + 30 + RD + RR,     5'b00010, 5'b00000);
        expect_ev(p + 30 + RD + 2 * RR, 5'b00010, 5'b00000);
        step(p + 120 - cyc);
        i_btn[1] = 1'b0;
        expect_ev(cyc + LAT, 5'b00000, 5'b00010);
        step(20);
        i_repeat_en[1] = 1'b0;

        // Simultaneous press on ch0 and ch3, reset mid-hold, held through reset release
        i_btn = 5'b01001;
        expect_ev(cyc + LAT, 5'b01001, 5'b00000);
        step(20);
        rst = 1'b0;
        step(3);
        rst = 1'b1;
        expect_ev(cyc + LAT, 5'b01001, 5'b00000);
        step(20);
        i_btn = '0;
        expect_ev(cyc + LAT, 5'b00000, 5'b01001);
        step(20);

        n_vec++;
        assert (sb_q.size() == 0) else begin
            n_miss++;
            $error("FAIL pending_events got=%0d exp=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
